// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS multiply/divide unit owning the HI/LO pair.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one bit per
// cycle. Sign handling is done on magnitudes and corrected in a final FIX cycle.
// Optional build macro MULDIV_DIVZERO_FAST_EN: divide-by-zero skips the
// iterations and an extra DivZero pulse output is provided.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIWrite,
    input  logic             LOWrite,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MULDIV_DIVZERO_FAST_EN
    ,
    output logic             DivZero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_r, state_n;
    logic               busy_r, done_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;          // operands exactly as issued
    logic [WIDTH-1:0]   mag_r;             // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_r;             // product high half / partial remainder
    logic [WIDTH-1:0]   work_r;            // multiplier bits / dividend -> quotient
    logic [CW-1:0]      cnt_r;
    logic               neg_q_r, neg_r_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
`ifdef MULDIV_DIVZERO_FAST_EN
    logic               divzero_r;
`endif

    logic               is_div_s, is_signed_s, a_neg_s, b_neg_s, b_zero_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     add_s, shifted_s;
    logic               ge_s;
    logic [WIDTH-1:0]   sub_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

    assign is_div_s    = op_r[1];
    assign is_signed_s = ~op_r[0];
    assign a_neg_s     = is_signed_s & a_r[WIDTH-1];
    assign b_neg_s     = is_signed_s & b_r[WIDTH-1];
    assign a_mag_s     = a_neg_s ? (-a_r) : a_r;
    assign b_mag_s     = b_neg_s ? (-b_r) : b_r;
    assign b_zero_s    = (b_r == {WIDTH{1'b0}});

    // One multiply step adds the multiplicand when the current multiplier bit
    // is set; the WIDTH+1 result carries into the shifted-down product.
    assign add_s       = {1'b0, acc_r} + (work_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
    // One divide step brings the next dividend bit into the partial remainder.
    assign shifted_s   = {acc_r, work_r[WIDTH-1]};
    assign ge_s        = (shifted_s >= {1'b0, mag_r});
    // Only used when ge_s holds, so the difference is below the divisor.
    assign sub_s       = shifted_s[WIDTH-1:0] - mag_r;

    assign prod_s      = {acc_r, work_r};
    assign prod_fix_s  = neg_q_r ? (-prod_s) : prod_s;

    // Final sign correction and MIPS divide-by-zero result selection.
    always_comb begin
        fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_fix_s[WIDTH-1:0];
        if (!is_div_s) begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end else if (b_zero_s) begin
            fix_hi_s = a_r;
            fix_lo_s = {WIDTH{1'b1}};
        end else begin
            fix_hi_s = neg_r_r ? (-acc_r) : acc_r;
            fix_lo_s = neg_q_r ? (-work_r) : work_r;
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (Start) state_n = PREP;
                else       state_n = IDLE;
            end
            PREP: begin
`ifdef MULDIV_DIVZERO_FAST_EN
                if (is_div_s && b_zero_s) state_n = FIX;
                else                      state_n = ITER;
`else
                state_n = ITER;
`endif
            end
            ITER: begin
                if (cnt_r == CW'(1)) state_n = FIX;
                else                 state_n = ITER;
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register and registered Busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n != IDLE);
        end
    end

    // Operand capture, iteration datapath and HI/LO register updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r      <= 2'd0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            mag_r     <= {WIDTH{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            work_r    <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
            divzero_r <= 1'b0;
`endif
        end else begin
            done_r    <= 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
            divzero_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        // An accepted Start drops any same-cycle MTHI/MTLO.
                        op_r <= Op;
                        a_r  <= A;
                        b_r  <= B;
                    end else begin
                        if (HIWrite) hi_r <= WData;
                        if (LOWrite) lo_r <= WData;
                    end
                end
                PREP: begin
                    acc_r   <= {WIDTH{1'b0}};
                    cnt_r   <= CW'(WIDTH);
                    neg_q_r <= a_neg_s ^ b_neg_s;
                    neg_r_r <= a_neg_s;
                    if (is_div_s) begin
                        work_r <= a_mag_s;
                        mag_r  <= b_mag_s;
                    end else begin
                        work_r <= b_mag_s;
                        mag_r  <= a_mag_s;
                    end
                end
                ITER: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (!is_div_s) begin
                        acc_r  <= add_s[WIDTH:1];
                        work_r <= {add_s[0], work_r[WIDTH-1:1]};
                    end else if (ge_s) begin
                        acc_r  <= sub_s;
                        work_r <= {work_r[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_r  <= shifted_s[WIDTH-1:0];
                        work_r <= {work_r[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    hi_r   <= fix_hi_s;
                    lo_r   <= fix_lo_s;
                    done_r <= 1'b1;
`ifdef MULDIV_DIVZERO_FAST_EN
                    divzero_r <= is_div_s & b_zero_s;
`endif
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;
`ifdef MULDIV_DIVZERO_FAST_EN
    assign DivZero = divzero_r;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed and randomized operations checked
// against an arithmetic reference model of MIPS HI/LO results.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        HIWrite = 1'b0;
    logic        LOWrite = 1'b0;
    logic [31:0] WData = 32'd0;
    logic        Busy, Done;
    logic [31:0] HI, LO;
`ifdef MULDIV_DIVZERO_FAST_EN
    logic        DivZero;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WData(WData),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
`ifdef MULDIV_DIVZERO_FAST_EN
        , .DivZero(DivZero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin u = 64'(sa * sb); return u; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_DIVZERO_FAST_EN
        if (op[1] && b == 32'd0) return 3;
`endif
        return 35;
    endfunction

    // Issue one operation at the current negedge and follow it to Done.
    // Leaves the bench at the negedge of the Done cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke, input logic lo_with_start);
        logic [31:0] hi0, lo0;
        logic [63:0] exp;
        int lat, bc, le;
        logic held;
        hi0 = HI;
        lo0 = LO;
        exp = model(op, a, b);
        le  = exp_latency(op, b);
        Start = 1'b1; Op = op; A = a; B = b;
        if (lo_with_start) begin
            LOWrite = 1'b1;
            WData   = 32'hDEADBEEF;
        end
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; LOWrite = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom_range(0, 3));
        lat = 1; bc = 0; held = 1'b1;
        while (!Done && lat < 100) begin
            if (Busy) bc++;
            if (HI !== hi0 || LO !== lo0) held = 1'b0;
            HIWrite = (lat == poke);
            WData   = 32'hCAFEF00D;
            @(negedge clk);
            lat++;
        end
        HIWrite = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(le));
        check({tag, " busy_cycles"}, 64'(bc), 64'(le - 1));
        check({tag, " busy_low_at_done"}, 64'(Busy), 64'd0);
        check({tag, " hilo_held"}, 64'(held), 64'd1);
        check({tag, " hilo"}, {HI, LO}, exp);
`ifdef MULDIV_DIVZERO_FAST_EN
        check({tag, " divzero"}, 64'(DivZero), 64'(op[1] && b == 32'd0));
`endif
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic        saw_done;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state", {28'd0, Busy, Done, 2'd0, HI, LO}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // MTHI, then MTHI+MTLO together
        HIWrite = 1'b1; WData = 32'h12345678;
        @(negedge clk);
        HIWrite = 1'b0;
        check("mthi", {32'd0, HI}, {32'd0, 32'h12345678});
        check("mthi_lo_untouched", {32'd0, LO}, 64'd0);
        HIWrite = 1'b1; LOWrite = 1'b1; WData = 32'hA5A5A5A5;
        @(negedge clk);
        HIWrite = 1'b0; LOWrite = 1'b0;
        check("mthi_mtlo_both", {HI, LO}, {32'hA5A5A5A5, 32'hA5A5A5A5});

        // Directed operations, back to back from the Done cycle
        run_op("mult_neg3x5", 2'd0, 32'hFFFFFFFD, 32'd5, 7, 1'b0);
        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1);
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 20, 1'b0);
        run_op("div_neg7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        run_op("div_min_neg1", 2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        run_op("divu_by_zero", 2'd3, 32'd100, 32'd0, 0, 1'b0);
        run_op("div_by_zero", 2'd2, 32'hFFFFFF00, 32'd0, 0, 1'b0);
        run_op("mult_min_min", 2'd0, 32'h80000000, 32'h80000000, 0, 1'b0);
        @(negedge clk);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), rop, ra, rb, $urandom_range(0, 30), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Asynchronous reset in the middle of an operation
        Start = 1'b1; Op = 2'd0; A = 32'd6; B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_async_clear", {28'd0, Busy, Done, 2'd0, HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (Done || Busy) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
